qos_req_agent: RTL

Requester-side agent for one port of the 32-way QoS round-robin arbiter. Buffers transactions from a local client in a small FIFO and drives the arbiter's per-port req and 4-bit qos from the FIFO head. Consumes the arbiter's same-cycle grant to pop the head and deliver it downstream. Escalates the presented QoS on starvation so a low-priority port cannot be locked out indefinitely.

---
 rtl/qos_req_agent.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/qos_req_agent.sv
// Requester-side agent for one port of a QoS round-robin arbiter.
// A small FIFO buffers client transactions; the head drives req/qos toward the
// arbiter, a same-cycle grant pops the head, and the popped payload appears on
// out_data one cycle later with an out_valid pulse. A head that keeps being
// denied has its presented QoS boosted step by step so it cannot starve.
module qos_req_agent #(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 4,
  parameter  int AGE_LIMIT = 16,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [3:0]    in_qos,
  output logic          req,
  output logic [3:0]    qos,
  input  logic          grant,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] level,
  output logic          err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // An AGE_LIMIT of 1 boosts on every denied cycle, so the age counter only
  // ever holds 0; keep it at least one bit wide.
  localparam int AW = (AGE_LIMIT > 1) ? $clog2(AGE_LIMIT) : 1;

  localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_LAST = AW'(AGE_LIMIT - 1);

  // Saturating 4-bit add used to combine base QoS with the starvation boost.
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

  // Saturating 4-bit increment for the boost counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] a);
    return (a == 4'hF) ? 4'hF : a + 4'd1;
  endfunction

  // FIFO storage (data only, never reset) and control state.
  logic [DW-1:0] mem_data [DEPTH];
  logic [3:0]    mem_qos  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] age;
  logic [3:0]    boost;
  logic          err_q;

  // Delivery register, one cycle behind the granting edge.
  logic          out_vld_p1;
  logic [DW-1:0] out_data_p1;

  logic full;
  logic empty;
  logic push_p0;
  logic pop_p0;
  logic [3:0] head_qos;

  // ---- Stage p0: request side, combinational from FIFO state and grant ----
  assign full     = (cnt == LVL_FULL);
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign req      = !empty;
  assign push_p0  = in_valid && !full;
  // A grant with nothing requested is a protocol error and never pops.
  assign pop_p0   = grant && !empty;
  assign head_qos = mem_qos[rd_ptr];
  assign qos      = empty ? 4'd0 : sat_add4(head_qos, boost);
  assign level    = cnt;
  assign err      = err_q;

  // Write the offered transaction into the tail slot.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_data[wr_ptr] <= in_data;
      mem_qos[wr_ptr]  <= in_qos;
    end
  end

  // Pointer and occupancy bookkeeping; full/empty derive from the count only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Starvation aging: count denied request cycles and step the boost each
  // time the limit is reached; a pop or an idle port clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age   <= '0;
      boost <= '0;
    end else if (pop_p0 || !req) begin
      age   <= '0;
      boost <= '0;
    end else if (age == AGE_LAST) begin
      age   <= '0;
      boost <= sat_inc4(boost);
    end else begin
      age   <= age + 1'b1;
    end
  end

  // Sticky flag for a grant arriving while no request is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (grant && !req) begin
      err_q <= 1'b1;
    end
  end

  // ---- Stage p1: deliver the popped head; data holds between pops ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
    end else begin
      out_vld_p1 <= pop_p0;
      if (pop_p0) out_data_p1 <= mem_data[rd_ptr];
    end
  end

  assign out_valid = out_vld_p1;
  assign out_data  = out_data_p1;

endmodule
